abl: RTL and testbench
======================

ABL -- requirements
Module: abl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; ports named clk and RST as in the codebase (RST low = reset).
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 RST  in  1  synchronous active-low reset; sampled on the rising edge of clk.
REQ-004 op  in  5  address-low operation: op[4:2] base select, op[1:0] addend select.
REQ-005 CI  in  1  carry into the address-low adder.
REQ-006 CO  out  1  carry out of the address-low adder, combinational, feeds the high-byte block.
REQ-007 ld_ahl  in  1  load enable for the AHL hold register.
REQ-008 ld_pc  in  1  load enable for PCL from ADL.
REQ-009 inc_pc  in  1  increment request for PCL.
REQ-010 pcl_co  out  1  carry out of the PCL increment, combinational.
REQ-011 PCL  out  8  program counter low register.
REQ-012 ADL  out  8  address bus low, combinational adder result.
REQ-013 DB  in  8  data bus input.
REQ-014 REG  in  8  register-file read value (index or stack pointer).

Function
REQ-015 Base select op[4:2]: 000 ABL reg (hold), 001 PCL, 010 DB, 011 AHL, 100 REG, 101 8'h00, 110 8'hFF, 111 8'h00.
REQ-016 Addend select op[1:0]: 00 8'h00, 01 REG, 10 DB, 11 8'hFF (only with ABL_DEC_EN, see REQ-027).
REQ-017 9-bit sum = base + addend + CI; ADL = sum[7:0]; CO = sum[8]; all combinational in the same cycle, no latency.
REQ-018 Arithmetic SHALL wrap modulo 256 on ADL; e.g. 8'hFF + 8'h01 + 0 gives ADL 8'h00, CO 1.
REQ-019 Internal ABL register SHALL load ADL on every rising edge when not in reset; it is the base for op[4:2]=000.
REQ-020 AHL SHALL load DB on a rising edge when ld_ahl=1, and hold otherwise.
REQ-021 PCL next value: ld_pc=1 gives ADL + inc_pc; ld_pc=0 gives PCL + inc_pc; 8-bit wrap.
REQ-022 pcl_co SHALL be 1 when inc_pc=1 and the increment source (ADL if ld_pc else PCL) equals 8'hFF, else 0; combinational.
REQ-023 Simultaneous ld_pc and inc_pc SHALL both apply (load then increment in one cycle); simultaneous ld_ahl and base=AHL SHALL use the old AHL in the current cycle.

Reset
REQ-024 RST low at a rising edge SHALL clear ABL, AHL and PCL to 8'h00, overriding all load and increment enables.
REQ-025 During reset the combinational outputs ADL, CO and pcl_co SHALL still follow REQ-017 and REQ-022 from the current register values and inputs.
REQ-026 Reset asserted mid-operation SHALL take effect on that edge; the first edge with RST high resumes normal updates.

Configuration
REQ-027 Macro ABL_DEC_EN: when defined, addend 11 selects 8'hFF (decrement or negative index); when undefined, addend 11 selects 8'h00 and no FF-addend logic SHALL be generated.

Structure
REQ-028 A shared package abl_pkg SHALL hold localparams for the base-select and addend-select encodings, used by abl and by microcode tables.
REQ-029 One sub-module abl_add8 (8-bit adder with carry in/out) is natural; base/addend muxes and registers stay in abl.

Verification
REQ-030 Reset: RST=0 for one edge with ld_pc=1, inc_pc=1 -> PCL=00, AHL=00, ABL=00.
REQ-031 PC fetch: base=PCL(001), addend 00, CI=0, inc_pc=1, PCL=8'hFE -> ADL=FE, then PCL=FF with pcl_co=0; next cycle pcl_co=1 and PCL wraps to 00.
REQ-032 Indexed: base DB(010)=8'hF0, addend REG=8'h20, CI=0 -> ADL=10, CO=1.
REQ-033 Jump load: ld_ahl=1 with DB=8'h34, next cycle base AHL(011), ld_pc=1, inc_pc=0 -> ADL=34 and PCL becomes 34.
REQ-034 Hold/carry: base ABL(000)=8'h7F, addend 00, CI=1 -> ADL=80, CO=0, and ABL register becomes 80 on the edge.
REQ-035 ABL_DEC_EN: base REG=8'h00, addend 11, CI=0 -> ADL=FF, CO=0 when defined; ADL=00 when undefined.

Source files
------------

// File: rtl/abl_pkg.sv
// abl_pkg: shared select encodings for the address-low block and microcode tables.
// Contents: base-select (op[4:2]) and addend-select (op[1:0]) localparams, constant operands.
// Optional feature macro ABL_DEC_EN is consumed in abl.sv; encodings here are unconditional.
package abl_pkg;

  // Base select, op[4:2]
  localparam logic [2:0] BASE_ABL  = 3'b000;
  localparam logic [2:0] BASE_PCL  = 3'b001;
  localparam logic [2:0] BASE_DB   = 3'b010;
  localparam logic [2:0] BASE_AHL  = 3'b011;
  localparam logic [2:0] BASE_REG  = 3'b100;
  localparam logic [2:0] BASE_ZERO = 3'b101;
  localparam logic [2:0] BASE_ONES = 3'b110;
  localparam logic [2:0] BASE_ZER2 = 3'b111;

  // Addend select, op[1:0]
  localparam logic [1:0] ADD_ZERO = 2'b00;
  localparam logic [1:0] ADD_REG  = 2'b01;
  localparam logic [1:0] ADD_DB   = 2'b10;
  localparam logic [1:0] ADD_ONES = 2'b11;

  localparam logic [7:0] BYTE_ZERO = 8'h00;
  localparam logic [7:0] BYTE_ONES = 8'hFF;

endpackage

// File: rtl/abl_add8.sv
// abl_add8: 8-bit ripple adder with carry in and carry out.
// Ports: i_a, i_b (8b operands), i_ci (carry in) -> o_sum (8b), o_co (carry out).
// Latency: purely combinational; no backpressure.
module abl_add8 (
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  input  logic       i_ci,
  output logic [7:0] o_sum,
  output logic       o_co
);

  logic [8:0] w_sum;

  assign w_sum = {1'b0, i_a} + {1'b0, i_b} + {8'h00, i_ci};
  assign o_sum = w_sum[7:0];
  assign o_co  = w_sum[8];

endmodule

// File: rtl/abl.sv
// abl: address-bus-low unit; base/addend muxes feed an 8-bit adder driving ADL/CO,
//   with ABL hold, AHL hold and PCL registers. Ports: clk, RST (sync, active low), op, CI,
//   ld_ahl, ld_pc, inc_pc, DB, REG in; ADL, CO, PCL, pcl_co out. Macro ABL_DEC_EN enables addend FF.
module abl
  import abl_pkg::*;
(
  input  logic       clk,
  input  logic       RST,
  input  logic [4:0] op,
  input  logic       CI,
  output logic       CO,
  input  logic       ld_ahl,
  input  logic       ld_pc,
  input  logic       inc_pc,
  output logic       pcl_co,
  output logic [7:0] PCL,
  output logic [7:0] ADL,
  input  logic [7:0] DB,
  input  logic [7:0] REG
);

  logic [7:0] r_abl;
  logic [7:0] r_ahl;
  logic [7:0] r_pcl;

  logic [7:0] w_base;
  logic [7:0] w_addend;
  logic [7:0] w_adl;
  logic       w_co;
  logic [7:0] w_inc_src;

  always_comb begin
    w_base = BYTE_ZERO;
    unique case (op[4:2])
      BASE_ABL:  w_base = r_abl;
      BASE_PCL:  w_base = r_pcl;
      BASE_DB:   w_base = DB;
      BASE_AHL:  w_base = r_ahl;   // old AHL even while ld_ahl is loading it
      BASE_REG:  w_base = REG;
      BASE_ZERO: w_base = BYTE_ZERO;
      BASE_ONES: w_base = BYTE_ONES;
      BASE_ZER2: w_base = BYTE_ZERO;
      default:   w_base = BYTE_ZERO;
    endcase
  end

  always_comb begin
    w_addend = BYTE_ZERO;
    unique case (op[1:0])
      ADD_ZERO: w_addend = BYTE_ZERO;
      ADD_REG:  w_addend = REG;
      ADD_DB:   w_addend = DB;
`ifdef ABL_DEC_EN
      ADD_ONES: w_addend = BYTE_ONES;
`else
      ADD_ONES: w_addend = BYTE_ZERO;
`endif
      default:  w_addend = BYTE_ZERO;
    endcase
  end

  abl_add8 u_add8 (
    .i_a   (w_base),
    .i_b   (w_addend),
    .i_ci  (CI),
    .o_sum (w_adl),
    .o_co  (w_co)
  );

  assign ADL = w_adl;
  assign CO  = w_co;

  // Load-then-increment: the increment applies to ADL when loading, else to PCL.
  assign w_inc_src = ld_pc ? w_adl : r_pcl;
  assign pcl_co    = inc_pc & (w_inc_src == BYTE_ONES);
  assign PCL       = r_pcl;

  always_ff @(posedge clk) begin
    if (!RST) begin
      r_abl <= BYTE_ZERO;
      r_ahl <= BYTE_ZERO;
      r_pcl <= BYTE_ZERO;
    end else begin
      r_abl <= w_adl;
      if (ld_ahl) begin
        r_ahl <= DB;
      end
      r_pcl <= w_inc_src + {7'b0, inc_pc};
    end
  end

endmodule

// File: tb/tb_abl.sv
// tb_abl: table-driven check of abl with a scoreboard queue of expected results.
// Each vector drives inputs at negedge, checks ADL/CO/pcl_co mid-cycle, then PCL after the edge.
// Expected values are hand-derived per vector; ABL_DEC_EN selects the decrement expectation.
module tb_abl;
  logic       clk;
  logic       RST;
  logic [4:0] op;
  logic       CI;
  logic       CO;
  logic       ld_ahl;
  logic       ld_pc;
  logic       inc_pc;
  logic       pcl_co;
  logic [7:0] PCL;
  logic [7:0] ADL;
  logic [7:0] DB;
  logic [7:0] REG;

  abl dut (
    .clk    (clk),
    .RST    (RST),
    .op     (op),
    .CI     (CI),
    .CO     (CO),
    .ld_ahl (ld_ahl),
    .ld_pc  (ld_pc),
    .inc_pc (inc_pc),
    .pcl_co (pcl_co),
    .PCL    (PCL),
    .ADL    (ADL),
    .DB     (DB),
    .REG    (REG)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [4:0] op;
    logic       ci;
    logic [7:0] db;
    logic [7:0] rg;
    logic       ld_ahl;
    logic       ld_pc;
    logic       inc_pc;
    logic [7:0] e_adl;
    logic       e_co;
    logic       e_pco;
    logic [7:0] e_pcl;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   n_vec;
  int   n_err;

  function automatic vec_t mk(input logic rst, input logic [2:0] base, input logic [1:0] add,
                              input logic ci, input logic [7:0] db, input logic [7:0] rg,
                              input logic la, input logic lp, input logic ip,
                              input logic [7:0] e_adl, input logic e_co, input logic e_pco,
                              input logic [7:0] e_pcl);
    vec_t v;
    v.rst = rst; v.op = {base, add}; v.ci = ci; v.db = db; v.rg = rg;
    v.ld_ahl = la; v.ld_pc = lp; v.inc_pc = ip;
    v.e_adl = e_adl; v.e_co = e_co; v.e_pco = e_pco; v.e_pcl = e_pcl;
    return v;
  endfunction

  task automatic chk(input int idx, input string what, input logic [7:0] act, input logic [7:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL vec %0d %s: got %02h expected %02h", idx, what, act, exp);
    end
  endtask

  task automatic apply(input int idx, input vec_t v);
    vec_t e;
    @(negedge clk);
    RST = v.rst; op = v.op; CI = v.ci; DB = v.db; REG = v.rg;
    ld_ahl = v.ld_ahl; ld_pc = v.ld_pc; inc_pc = v.inc_pc;
    sb.push_back(v);
    n_vec++;
    #1;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL vec %0d scoreboard: got empty queue expected entry", idx);
    end else begin
      e = sb.pop_front();
      chk(idx, "ADL", ADL, e.e_adl);
      chk(idx, "CO", {7'b0, CO}, {7'b0, e.e_co});
      chk(idx, "pcl_co", {7'b0, pcl_co}, {7'b0, e.e_pco});
      @(posedge clk);
      #1;
      chk(idx, "PCL", PCL, e.e_pcl);
    end
  endtask

  logic [7:0] dec_adl;

  initial begin
    n_vec = 0;
    n_err = 0;
`ifdef ABL_DEC_EN
    dec_adl = 8'hFF;
`else
    dec_adl = 8'h00;
`endif
    RST = 1'b0; op = 5'b0; CI = 1'b0; DB = 8'h00; REG = 8'h00;
    ld_ahl = 1'b0; ld_pc = 1'b0; inc_pc = 1'b0;

    //        rst base    add    ci db     reg    la lp ip  adl    co pco pcl
    tbl.push_back(mk(1, 3'b000, 2'b00, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 0, 8'h00)); // ABL cleared
    tbl.push_back(mk(1, 3'b011, 2'b00, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 0, 8'h00)); // AHL cleared
    tbl.push_back(mk(1, 3'b010, 2'b00, 0, 8'hFE, 8'h00, 0, 1, 0, 8'hFE, 0, 0, 8'hFE)); // PCL<=FE
    tbl.push_back(mk(1, 3'b001, 2'b00, 0, 8'h00, 8'h00, 0, 0, 1, 8'hFE, 0, 0, 8'hFF)); // fetch
    tbl.push_back(mk(1, 3'b001, 2'b00, 0, 8'h00, 8'h00, 0, 0, 1, 8'hFF, 0, 1, 8'h00)); // wrap
    tbl.push_back(mk(1, 3'b010, 2'b01, 0, 8'hF0, 8'h20, 0, 0, 0, 8'h10, 1, 0, 8'h00)); // indexed
    tbl.push_back(mk(1, 3'b011, 2'b00, 0, 8'h34, 8'h00, 1, 0, 0, 8'h00, 0, 0, 8'h00)); // old AHL
    tbl.push_back(mk(1, 3'b011, 2'b00, 0, 8'h00, 8'h00, 0, 1, 0, 8'h34, 0, 0, 8'h34)); // jump
    tbl.push_back(mk(1, 3'b100, 2'b00, 0, 8'h00, 8'h7F, 0, 0, 0, 8'h7F, 0, 0, 8'h34)); // ABL<=7F
    tbl.push_back(mk(1, 3'b000, 2'b00, 1, 8'h00, 8'h00, 0, 0, 0, 8'h80, 0, 0, 8'h34)); // hold+CI
    tbl.push_back(mk(1, 3'b000, 2'b00, 0, 8'h00, 8'h00, 0, 0, 0, 8'h80, 0, 0, 8'h34)); // ABL=80
    tbl.push_back(mk(1, 3'b110, 2'b00, 1, 8'h00, 8'h00, 0, 1, 1, 8'h00, 1, 0, 8'h01)); // FF+1
    tbl.push_back(mk(1, 3'b110, 2'b00, 0, 8'h00, 8'h00, 0, 1, 1, 8'hFF, 0, 1, 8'h00)); // ld+inc FF
    tbl.push_back(mk(1, 3'b100, 2'b10, 0, 8'h01, 8'hFF, 0, 0, 0, 8'h00, 1, 0, 8'h00)); // REG+DB wrap
    tbl.push_back(mk(1, 3'b100, 2'b11, 0, 8'h00, 8'h00, 0, 0, 0, dec_adl, 0, 0, 8'h00)); // addend 11
    tbl.push_back(mk(1, 3'b101, 2'b01, 1, 8'h00, 8'h05, 0, 0, 0, 8'h06, 0, 0, 8'h00)); // zero+REG+1
    tbl.push_back(mk(1, 3'b111, 2'b10, 0, 8'hAA, 8'h00, 0, 0, 0, 8'hAA, 0, 0, 8'h00)); // zero+DB
    tbl.push_back(mk(1, 3'b101, 2'b00, 0, 8'h00, 8'h00, 0, 0, 1, 8'h00, 0, 0, 8'h01)); // PCL inc
    // Mid-operation reset, then resume
    tbl.push_back(mk(0, 3'b010, 2'b00, 0, 8'h77, 8'h00, 1, 1, 1, 8'h77, 0, 0, 8'h00));
    tbl.push_back(mk(1, 3'b000, 2'b00, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 0, 8'h00));
    tbl.push_back(mk(1, 3'b011, 2'b00, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 0, 8'h00));
    tbl.push_back(mk(1, 3'b010, 2'b00, 0, 8'h12, 8'h00, 0, 1, 1, 8'h12, 0, 0, 8'h13));

    repeat (2) @(posedge clk);

    // Hand sequence: a reset edge with every enable asserted; combinational outputs still live.
    apply(-1, mk(0, 3'b110, 2'b00, 0, 8'h55, 8'h00, 1, 1, 1, 8'hFF, 0, 1, 8'h00));

    for (int i = 0; i < tbl.size(); i++) begin
      apply(i, tbl[i]);
    end

    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard drain: got %0d entries expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
